led_display_arbiter: RTL and testbench
======================================

# led_display_arbiter

Shares the board's single 8-bit LED bank among three display requesters (note indicator, level meter, status) of the tone organ player, with fixed priority and a minimum on-screen hold time to suppress flicker. When no requester is active it drives a walking-one idle chase. It sits between the requester blocks and the LED pins and replaces direct `led` driving by any single block.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per display tick; legal range ≥ 2.
- `HOLD_TICKS`, default 2: minimum ownership in ticks once granted; legal range ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  3  request per requester; bit 0 is highest priority.
- `pat0`, `pat1`, `pat2`  in  8 each  pattern offered by requester 0/1/2.
- `grant`  out  3  one-hot owner, or 0 in IDLE; registered.
- `led`  out  8  LED drive; registered.
- `busy`  out  1  high whenever state ≠ IDLE; registered.

## Operation
- Tick generator: counter runs 0..TICK_DIV-1. `tick` is a 1-cycle pulse when count = TICK_DIV-1, then the counter wraps to 0. It free-runs in all states.
- IDLE: `grant`=0. `led` = chase register, which starts at 8'h01 and rotates left on each tick (8'h80 → 8'h01). The chase register freezes outside IDLE and resumes from the same value on return.
- Grant rule: choose the lowest-index set bit of the relevant request set.
- IDLE → HOLD: when any `req` is set. Grant that index and load `hold_cnt` = HOLD_TICKS.
- HOLD:
  - While the owner's req is high, `led` follows `pat[owner]`. If the owner drops req, `led` freezes at its last value.
  - Other requests are ignored.
  - Each tick decrements `hold_cnt`. A tick with `hold_cnt`=1 ends the hold and triggers an expiry decision in that same cycle:
    - If any `req` bit of higher priority than the owner is set, switch to the highest such requester → HOLD, with reload.
    - Else, if the owner's req is still set → KEEP.
    - Else, if any lower-priority req is set, switch to the highest of them → HOLD, with reload.
    - Else → IDLE.
- KEEP: `led` follows `pat[owner]`. Re-evaluated every cycle:
  - A higher-priority req preempts → HOLD, with reload.
  - If the owner drops req, arbitrate among the remaining reqs → HOLD, or → IDLE if none.
- Same-cycle tick and new request in IDLE: the grant wins and the chase does not advance.
- `rst` overrides everything, including mid-hold:
  - state=IDLE, `grant`=0, `led`=8'h00, `busy`=0.
  - chase=8'h01, tick counter=0, `hold_cnt`=0.
- First cycle after reset: `led`=8'h01.

## Timing
- All outputs are registered. A request sampled at edge n produces `grant`/`led`/`busy` valid after edge n+1 (1-cycle latency).
- The pattern path has the same 1-cycle latency: `pat` sampled at edge n appears on `led` after edge n+1.
- Hold duration is quantized to ticks. Ownership lasts between (HOLD_TICKS-1)·TICK_DIV+1 and HOLD_TICKS·TICK_DIV cycles, depending on tick phase at grant.
- `grant` is always one-hot or zero. It never shows two bits and never changes without a state transition.
- The chase advances exactly once per tick while in IDLE.

## Structure
- Package `led_arb_pkg`: state enum {IDLE, HOLD, KEEP}, `N_REQ`=3, `CHASE_SEED`=8'h01, `LED_OFF`=8'h00.
- Sub-module `led_tick_gen`, parameterised by TICK_DIV, outputs `tick`. Reuse it for other tick-paced display blocks.
- The top level holds the FSM, the priority encoder (a function), the hold counter, the chase register and the output registers.

## Test plan
All scenarios use TICK_DIV=4, HOLD_TICKS=2.
- Reset then no req: `led` sequence is 8'h00, then 8'h01, stepping 02, 04, … 80, 01 every 4 cycles. `busy`=0 and `grant`=0 throughout.
- Assert req=3'b100 with pat2=8'hA5: one cycle later, `grant`=3'b100, `led`=8'hA5, `busy`=1. Drop req after 1 cycle: `led` holds 8'hA5 until the second tick, then returns to IDLE and the chase resumes from its frozen value.
- Owner req=3'b100 in HOLD; raise req[0] with pat0=8'h0F mid-hold: no switch before expiry. At the expiry tick, `grant`=3'b001 and `led`=8'h0F on the next cycle.
- Owner 3'b010 in KEEP; raise req[0]: switch in 1 cycle. Raise req[2] instead: no change.
- Owner 3'b001 drops req while req[2] is set: `grant` goes to 3'b100 with a fresh hold. Verify `grant` stays one-hot every cycle via assertion.
- Assert `rst` mid-HOLD: the next cycle shows `led`=8'h00, `grant`=0, `busy`=0. After `rst` falls, chase restarts at 8'h01.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter and its tick source.
// Latency: none (declarations and pure functions only).
// Backpressure: none; requesters hold req until they see grant.
package led_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        KEEP = 2'd2
    } state_t;

    localparam int         N_REQ      = 3;
    localparam logic [7:0] CHASE_SEED = 8'h01;
    localparam logic [7:0] LED_OFF    = 8'h00;

    // Lowest-index set bit wins; result is one-hot or zero.
    function automatic logic [N_REQ-1:0] pick_first(input logic [N_REQ-1:0] r);
        logic [N_REQ-1:0] g;
        g = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Bits of strictly higher priority (lower index) than a one-hot owner.
    function automatic logic [N_REQ-1:0] higher_mask(input logic [N_REQ-1:0] owner);
        logic [N_REQ-1:0] m;
        logic             found;
        m     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner[i]) found = 1'b1;
            if (!found)   m[i]  = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles.
// Latency: tick is decoded from the counter, high while count = TICK_DIV-1.
// Backpressure: none; the counter never stalls.
module led_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Count 0..TICK_DIV-1 and wrap on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst)       count <= '0;
        else if (tick) count <= '0;
        else           count <= count + CW'(1);
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Shares one 8-bit LED bank among three requesters with fixed priority and tick-quantised minimum hold; idle shows a walking-one chase.
// Latency: 1 cycle from req/pat sampled to grant/led/busy, all registered.
// Backpressure: none; losers simply stay unserved until the owner's hold expires or it is preempted.
module led_display_arbiter
    import led_arb_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [7:0]       pat0,
    input  logic [7:0]       pat1,
    input  logic [7:0]       pat2,
    output logic [N_REQ-1:0] grant,
    output logic [7:0]       led,
    output logic             busy
);

    localparam int            HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [7:0]       chase;
    logic             tick;
    logic             owner_req;
    logic [N_REQ-1:0] hi_req;
    logic [N_REQ-1:0] lo_req;
    logic [N_REQ-1:0] new_grant;
    logic             decide;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic logic [7:0] pat_of(input logic [N_REQ-1:0] g,
                                          input logic [7:0] p0,
                                          input logic [7:0] p1,
                                          input logic [7:0] p2);
        if (g[0])      return p0;
        else if (g[1]) return p1;
        else if (g[2]) return p2;
        else           return LED_OFF;
    endfunction

    assign owner_req = |(req & grant);
    assign hi_req    = req & higher_mask(grant);
    assign lo_req    = req & ~(higher_mask(grant) | grant);

    // Arbitration happens every cycle in KEEP, but only on the last tick of a hold.
    assign decide = (state == KEEP) ||
                    ((state == HOLD) && tick && (hold_cnt == HW'(1)));

    // Higher priority always wins; lower priority only once the owner has let go.
    always_comb begin
        new_grant = '0;
        if (|hi_req)         new_grant = pick_first(hi_req);
        else if (!owner_req) new_grant = pick_first(lo_req);
    end

    // Ownership FSM together with the chase, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            led      <= LED_OFF;
            busy     <= 1'b0;
            chase    <= CHASE_SEED;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        // A grant on a tick cycle takes precedence; chase stays put.
                        state    <= HOLD;
                        grant    <= pick_first(req);
                        led      <= pat_of(pick_first(req), pat0, pat1, pat2);
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        led <= chase;
                        if (tick) chase <= {chase[6:0], chase[7]};
                    end
                end
                default: begin
                    // HOLD and KEEP share the expiry/re-evaluation decision.
                    if ((state == HOLD) && tick && !decide)
                        hold_cnt <= hold_cnt - HW'(1);
                    if (decide) begin
                        if (|new_grant) begin
                            state    <= HOLD;
                            grant    <= new_grant;
                            led      <= pat_of(new_grant, pat0, pat1, pat2);
                            hold_cnt <= HOLD_LOAD;
                        end else if (owner_req) begin
                            state    <= KEEP;
                            led      <= pat_of(grant, pat0, pat1, pat2);
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            grant    <= '0;
                            busy     <= 1'b0;
                            led      <= chase;
                            hold_cnt <= '0;
                        end
                    end else if (owner_req) begin
                        led <= pat_of(grant, pat0, pat1, pat2);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter with TICK_DIV=4, HOLD_TICKS=2.
// Latency: expectations are pushed with the stimulus and popped one edge later.
// Backpressure: n/a.
module tb_led_display_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [7:0] pat0, pat1, pat2;
    logic [2:0] grant;
    logic [7:0] led;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic mon_on = 1'b0;

    typedef struct {
        logic       chk;
        logic [2:0] g;
        logic [7:0] l;
        logic       b;
    } exp_t;

    exp_t sb[$];

    led_display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat0  (pat0),
        .pat1  (pat1),
        .pat2  (pat2),
        .grant (grant),
        .led   (led),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // grant must be one-hot or zero on every cycle
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL grant_onehot: grant=%b is not one-hot/zero", grant);
            end
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic r, input logic [2:0] q,
                        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                        input logic c, input logic [2:0] eg, input logic [7:0] el, input logic eb);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = q;
        pat0 = p0;
        pat1 = p1;
        pat2 = p2;
        e.chk = c;
        e.g   = eg;
        e.l   = el;
        e.b   = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        step(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, 8'h00, 1'b0);
        e = sb.pop_front();
        checks++;
        if (grant !== e.g || led !== e.l || busy !== e.b) begin
            errors++;
            $display("FAIL reset: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                     grant, led, busy, e.g, e.l, e.b);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_idle_chase();
        exp_t e;
        logic [7:0] seed;
        seed = 8'h01;
        for (int s = 1; s <= 36; s++) begin
            step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000, seed << (((s - 1) / 4) % 8), 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL idle_chase s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    task automatic test_hold_release();
        exp_t e;
        logic [2:0] q, eg;
        logic [7:0] p2, el;
        logic       eb;
        test_reset();
        for (int s = 1; s <= 17; s++) begin
            q  = (s == 6 || s == 7) ? 3'b100 : 3'b000;
            p2 = (s <= 7) ? 8'hA5 : 8'h3C;
            if (s <= 4)       begin eg = 3'b000; el = 8'h01; eb = 1'b0; end
            else if (s == 5)  begin eg = 3'b000; el = 8'h02; eb = 1'b0; end
            else if (s <= 11) begin eg = 3'b100; el = 8'hA5; eb = 1'b1; end
            else if (s <= 16) begin eg = 3'b000; el = 8'h02; eb = 1'b0; end
            else              begin eg = 3'b000; el = 8'h04; eb = 1'b0; end
            step(1'b0, q, 8'h00, 8'h00, p2, 1'b1, eg, el, eb);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL hold_release s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    task automatic test_preempt_hold();
        exp_t e;
        for (int s = 1; s <= 9; s++) begin
            if (s == 1) test_reset();
            step(1'b0, (s == 1) ? 3'b100 : 3'b101, 8'h0F, 8'h00, 8'h11, 1'b1,
                 (s <= 7) ? 3'b100 : 3'b001, (s <= 7) ? 8'h11 : 8'h0F, 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL preempt_hold s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    task automatic test_keep_preempt();
        exp_t e;
        logic [2:0] q, eg;
        logic [7:0] el;
        test_reset();
        for (int s = 1; s <= 11; s++) begin
            if (s <= 8)       begin q = 3'b010; eg = 3'b010; el = 8'h22; end
            else if (s <= 10) begin q = 3'b110; eg = 3'b010; el = 8'h23; end
            else              begin q = 3'b011; eg = 3'b001; el = 8'h0F; end
            step(1'b0, q, 8'h0F, (s <= 8) ? 8'h22 : 8'h23, 8'h99, 1'b1, eg, el, 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL keep_preempt s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    // Continues from test_keep_preempt: owner 001 granted on edge 11 of that timeline.
    task automatic test_owner_drop();
        exp_t e;
        logic [2:0] q, eg;
        logic [7:0] el;
        for (int s = 12; s <= 25; s++) begin
            if (s <= 16)      q = 3'b011;
            else if (s == 17) q = 3'b100;
            else              q = 3'b101;
            if (s <= 16)      begin eg = 3'b001; el = 8'h0F; end
            else if (s <= 23) begin eg = 3'b100; el = 8'h77; end
            else              begin eg = 3'b001; el = 8'h0F; end
            step(1'b0, q, 8'h0F, 8'h23, 8'h77, 1'b1, eg, el, 1'b1);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL owner_drop s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    task automatic test_tick_collision();
        exp_t e;
        logic [2:0] eg;
        logic [7:0] el;
        logic       eb;
        test_reset();
        for (int s = 1; s <= 17; s++) begin
            if (s <= 3)       begin eg = 3'b000; el = 8'h01; eb = 1'b0; end
            else if (s <= 11) begin eg = 3'b010; el = 8'h44; eb = 1'b1; end
            else if (s <= 16) begin eg = 3'b000; el = 8'h01; eb = 1'b0; end
            else              begin eg = 3'b000; el = 8'h02; eb = 1'b0; end
            step(1'b0, (s == 4) ? 3'b010 : 3'b000, 8'h00, 8'h44, 8'h00, 1'b1, eg, el, eb);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL tick_collision s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        test_reset();
        for (int s = 1; s <= 9; s++) begin
            if (s <= 2)
                step(1'b0, 3'b100, 8'h00, 8'h00, 8'hA5, 1'b1, 3'b100, 8'hA5, 1'b1);
            else if (s == 3)
                step(1'b1, 3'b100, 8'h00, 8'h00, 8'hA5, 1'b1, 3'b000, 8'h00, 1'b0);
            else
                step(1'b0, 3'b000, 8'h00, 8'h00, 8'hA5, 1'b1, 3'b000,
                     (s - 3 <= 4) ? 8'h01 : 8'h02, 1'b0);
            e = sb.pop_front();
            checks++;
            if (grant !== e.g || led !== e.l || busy !== e.b) begin
                errors++;
                $display("FAIL reset_mid_hold s=%0d: grant=%b led=%h busy=%b, want grant=%b led=%h busy=%b",
                         s, grant, led, busy, e.g, e.l, e.b);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 3'b000;
        pat0 = 8'h00;
        pat1 = 8'h00;
        pat2 = 8'h00;
        test_reset();
        test_idle_chase();
        test_hold_release();
        test_preempt_hold();
        test_keep_preempt();
        test_owner_drop();
        test_tick_collision();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
